branch_redirect_unit: RTL and testbench

- Sits between the fetch stage and decode, and acts as the control end of the fetch interface.
- Holds the IF/ID pipeline register and decodes control-flow instructions from it.
- Drives the fetch-stage inputs: PCsrc, stall, kill, J_TypeImmediate, I_TypeImmediate and ReturnAddress.
- Keeps a circular return-address stack (RAS) for CALL/RET.

---
 rtl/branch_redirect_unit_if.sv | 21 ++
 rtl/branch_redirect_unit.sv | 101 ++++++++++
 tb/tb_branch_redirect_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_unit_if.sv
// rtl/branch_redirect_unit_if.sv - fetch-stage interface between fetch and the redirect unit
interface branch_redirect_unit_if;
    logic [15:0] instruction;
    logic [15:0] NPC;
    logic [1:0]  PCsrc;
    logic        stall;
    logic        kill;
    logic [15:0] J_TypeImmediate;
    logic [15:0] I_TypeImmediate;
    logic [15:0] ReturnAddress;

    // master is the fetch stage, slave is the redirect unit that steers it
    modport master (
        output instruction, NPC,
        input  PCsrc, stall, kill, J_TypeImmediate, I_TypeImmediate, ReturnAddress
    );
    modport slave (
        input  instruction, NPC,
        output PCsrc, stall, kill, J_TypeImmediate, I_TypeImmediate, ReturnAddress
    );
endinterface

// File: rtl/branch_redirect_unit.sv
// rtl/branch_redirect_unit.sv - IF/ID register, control-flow decode and return-address stack
module branch_redirect_unit #(
    parameter int          RAS_DEPTH = 8,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_redirect_unit_if.slave   fetch,
    input  logic                    hazard_stall,
    input  logic                    rs_equal,
    output logic [15:0]             id_instruction,
    output logic [15:0]             id_NPC,
    output logic                    ras_overflow,
    output logic                    ras_underflow
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;

    logic [15:0]      ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_prev;
    logic [CNT_W-1:0] count;
    logic [3:0]       opcode;
    logic [1:0]       pc_sel;
    logic             push;
    logic             pop;

    assign opcode  = id_instruction[15:12];
    assign sp_prev = sp - PTR_W'(1);

    always_comb begin
        pc_sel = 2'b00;
        if (!hazard_stall) begin
            case (opcode)
                OP_JMP, OP_CALL: pc_sel = 2'b01;
                OP_BEQ:          pc_sel = rs_equal  ? 2'b10 : 2'b00;
                OP_BNE:          pc_sel = !rs_equal ? 2'b10 : 2'b00;
                OP_RET:          pc_sel = 2'b11;
                default:         pc_sel = 2'b00;
            endcase
        end
    end

    assign push = !hazard_stall && (opcode == OP_CALL);
    assign pop  = !hazard_stall && (opcode == OP_RET);

    assign fetch.PCsrc           = pc_sel;
    assign fetch.kill            = (pc_sel != 2'b00);
    assign fetch.stall           = hazard_stall;
    assign fetch.J_TypeImmediate = {id_NPC[15:12], id_instruction[11:0]};
    assign fetch.I_TypeImmediate = id_NPC + {{10{id_instruction[5]}}, id_instruction[5:0]};
    assign fetch.ReturnAddress   = (count != '0) ? ras_mem[sp_prev] : 16'h0000;

    // A killed slot becomes NOP so the redirecting instruction cannot fire twice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instruction <= NOP_INSTR;
            id_NPC         <= 16'h0000;
        end else if (!hazard_stall) begin
            id_instruction <= fetch.kill ? NOP_INSTR : fetch.instruction;
            id_NPC         <= fetch.NPC;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[sp] <= id_NPC;
        end
    end

    // Circular stack: a push while full overwrites the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp            <= '0;
            count         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (push) begin
            sp <= sp + PTR_W'(1);
            if (count == RAS_FULL) begin
                ras_overflow <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (count != '0) begin
                sp    <= sp_prev;
                count <= count - CNT_W'(1);
            end else begin
                ras_underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_redirect_unit.sv
// tb/tb_branch_redirect_unit.sv - directed self-checking bench for branch_redirect_unit
module tb_branch_redirect_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hazard_stall;
    logic        rs_equal;
    logic [15:0] id_instruction;
    logic [15:0] id_NPC;
    logic        ras_overflow;
    logic        ras_underflow;
    int          n_checks = 0;
    int          n_fail = 0;

    branch_redirect_unit_if fif ();

    branch_redirect_unit #(.RAS_DEPTH(8), .NOP_INSTR(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch          (fif.slave),
        .hazard_stall   (hazard_stall),
        .rs_equal       (rs_equal),
        .id_instruction (id_instruction),
        .id_NPC         (id_NPC),
        .ras_overflow   (ras_overflow),
        .ras_underflow  (ras_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] instr, input logic [15:0] npc);
        fif.instruction = instr;
        fif.NPC         = npc;
        step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        hazard_stall = 1'b1;
        rst_n = 1'b0;
        #3;
        n_checks++; if (fif.stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall_follow: got %b want 1", fif.stall); end
        hazard_stall = 1'b0;
        #1;
        n_checks++; if (fif.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_low: got %b want 0", fif.stall); end
        n_checks++; if (fif.PCsrc !== 2'b00) begin n_fail++; $display("FAIL reset_pcsrc: got %b want 00", fif.PCsrc); end
        n_checks++; if (fif.kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill: got %b want 0", fif.kill); end
        n_checks++; if (fif.ReturnAddress !== 16'h0000) begin n_fail++; $display("FAIL reset_ra: got %h want 0000", fif.ReturnAddress); end
        n_checks++; if (id_instruction !== 16'h0000) begin n_fail++; $display("FAIL reset_id_instr: got %h want 0000", id_instruction); end
        n_checks++; if (id_NPC !== 16'h0000) begin n_fail++; $display("FAIL reset_id_npc: got %h want 0000", id_NPC); end
        n_checks++; if ({ras_overflow, ras_underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {ras_overflow, ras_underflow}); end
        #10;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            load(16'h1000 + 16'(i), 16'(i));
            n_checks++; if (id_NPC !== 16'(i)) begin n_fail++; $display("FAIL seq_id_npc[%0d]: got %h want %h", i, id_NPC, 16'(i)); end
            n_checks++; if (id_instruction !== 16'h1000 + 16'(i)) begin n_fail++; $display("FAIL seq_id_instr[%0d]: got %h", i, id_instruction); end
            n_checks++; if (fif.PCsrc !== 2'b00 || fif.kill !== 1'b0) begin n_fail++; $display("FAIL seq_redirect[%0d]: PCsrc %b kill %b want 00/0", i, fif.PCsrc, fif.kill); end
        end
    endtask

    task automatic test_jmp();
        load(16'hC123, 16'h5004);
        n_checks++; if (fif.PCsrc !== 2'b01) begin n_fail++; $display("FAIL jmp_pcsrc: got %b want 01", fif.PCsrc); end
        n_checks++; if (fif.J_TypeImmediate !== 16'h5123) begin n_fail++; $display("FAIL jmp_target: got %h want 5123", fif.J_TypeImmediate); end
        n_checks++; if (fif.kill !== 1'b1) begin n_fail++; $display("FAIL jmp_kill: got %b want 1", fif.kill); end
        load(16'h1111, 16'h5005);
        n_checks++; if (id_instruction !== 16'h0000) begin n_fail++; $display("FAIL jmp_bubble: got %h want 0000", id_instruction); end
        n_checks++; if (id_NPC !== 16'h5005) begin n_fail++; $display("FAIL jmp_bubble_npc: got %h want 5005", id_NPC); end
        n_checks++; if (fif.PCsrc !== 2'b00) begin n_fail++; $display("FAIL jmp_no_repeat: got %b want 00", fif.PCsrc); end
    endtask

    task automatic test_branch();
        rs_equal = 1'b1;
        load(16'h803E, 16'h0010);
        n_checks++; if (fif.PCsrc !== 2'b10) begin n_fail++; $display("FAIL beq_taken_pcsrc: got %b want 10", fif.PCsrc); end
        n_checks++; if (fif.I_TypeImmediate !== 16'h000E) begin n_fail++; $display("FAIL beq_target: got %h want 000E", fif.I_TypeImmediate); end
        rs_equal = 1'b0;
        #1;
        n_checks++; if (fif.PCsrc !== 2'b00 || fif.kill !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: PCsrc %b kill %b want 00/0", fif.PCsrc, fif.kill); end
        load(16'h9005, 16'hFFFF);
        n_checks++; if (fif.PCsrc !== 2'b10 || fif.kill !== 1'b1) begin n_fail++; $display("FAIL bne_taken: PCsrc %b kill %b want 10/1", fif.PCsrc, fif.kill); end
        n_checks++; if (fif.I_TypeImmediate !== 16'h0004) begin n_fail++; $display("FAIL bne_target_wrap: got %h want 0004", fif.I_TypeImmediate); end
        rs_equal = 1'b1;
        #1;
        n_checks++; if (fif.PCsrc !== 2'b00) begin n_fail++; $display("FAIL bne_not_taken: got %b want 00", fif.PCsrc); end
    endtask

    task automatic test_call_ret();
        load(16'hD000, 16'h0021);
        n_checks++; if (fif.PCsrc !== 2'b01) begin n_fail++; $display("FAIL call_pcsrc: got %b want 01", fif.PCsrc); end
        load(16'h0000, 16'h0022);
        n_checks++; if (fif.ReturnAddress !== 16'h0021) begin n_fail++; $display("FAIL call_tos: got %h want 0021", fif.ReturnAddress); end
        load(16'hE000, 16'h0030);
        n_checks++; if (fif.PCsrc !== 2'b11 || fif.kill !== 1'b1) begin n_fail++; $display("FAIL ret_pcsrc: PCsrc %b kill %b want 11/1", fif.PCsrc, fif.kill); end
        n_checks++; if (fif.ReturnAddress !== 16'h0021) begin n_fail++; $display("FAIL ret_target: got %h want 0021", fif.ReturnAddress); end
        load(16'h0000, 16'h0031);
        n_checks++; if (fif.ReturnAddress !== 16'h0000 || ras_underflow !== 1'b0) begin n_fail++; $display("FAIL ret_empty: ra %h uf %b want 0000/0", fif.ReturnAddress, ras_underflow); end
        load(16'hE000, 16'h0032);
        n_checks++; if (fif.PCsrc !== 2'b11 || fif.ReturnAddress !== 16'h0000) begin n_fail++; $display("FAIL ret_underflow_target: PCsrc %b ra %h want 11/0000", fif.PCsrc, fif.ReturnAddress); end
        load(16'h0000, 16'h0033);
        n_checks++; if (ras_underflow !== 1'b1) begin n_fail++; $display("FAIL ret_underflow_flag: got %b want 1", ras_underflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            load(16'hD000, 16'(i));
            load(16'h0000, 16'h0100);
            if (i == 8) begin
                n_checks++; if (ras_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", ras_overflow); end
            end
        end
        n_checks++; if (ras_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ras_overflow); end
        for (int k = 1; k <= 8; k++) begin
            load(16'hE000, 16'h0200);
            n_checks++; if (fif.ReturnAddress !== 16'(10 - k)) begin n_fail++; $display("FAIL ovf_pop[%0d]: got %h want %h", k, fif.ReturnAddress, 16'(10 - k)); end
            load(16'h0000, 16'h0201);
        end
        n_checks++; if (ras_underflow !== 1'b0) begin n_fail++; $display("FAIL ovf_no_uf: got %b want 0", ras_underflow); end
        load(16'hE000, 16'h0300);
        n_checks++; if (fif.ReturnAddress !== 16'h0000) begin n_fail++; $display("FAIL ovf_ninth_ra: got %h want 0000", fif.ReturnAddress); end
        load(16'h0000, 16'h0301);
        n_checks++; if (ras_underflow !== 1'b1) begin n_fail++; $display("FAIL ovf_ninth_uf: got %b want 1", ras_underflow); end
    endtask

    task automatic test_stall_and_async_reset();
        load(16'hC0AB, 16'h3000);
        hazard_stall = 1'b1;
        #1;
        n_checks++; if (fif.stall !== 1'b1) begin n_fail++; $display("FAIL stall_out: got %b want 1", fif.stall); end
        n_checks++; if (fif.PCsrc !== 2'b00 || fif.kill !== 1'b0) begin n_fail++; $display("FAIL stall_suppress: PCsrc %b kill %b want 00/0", fif.PCsrc, fif.kill); end
        load(16'h1234, 16'h3001);
        n_checks++; if (id_instruction !== 16'hC0AB || id_NPC !== 16'h3000) begin n_fail++; $display("FAIL stall_hold: id %h npc %h want C0AB/3000", id_instruction, id_NPC); end
        hazard_stall = 1'b0;
        #1;
        n_checks++; if (fif.PCsrc !== 2'b01 || fif.J_TypeImmediate !== 16'h30AB) begin n_fail++; $display("FAIL stall_release: PCsrc %b tgt %h want 01/30AB", fif.PCsrc, fif.J_TypeImmediate); end
        hazard_stall = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (id_instruction !== 16'h0000 || id_NPC !== 16'h0000) begin n_fail++; $display("FAIL areset_ifid: id %h npc %h want 0000/0000", id_instruction, id_NPC); end
        n_checks++; if (fif.PCsrc !== 2'b00 || fif.kill !== 1'b0 || fif.ReturnAddress !== 16'h0000) begin n_fail++; $display("FAIL areset_outs: PCsrc %b kill %b ra %h", fif.PCsrc, fif.kill, fif.ReturnAddress); end
        n_checks++; if ({ras_overflow, ras_underflow} !== 2'b00 || fif.stall !== 1'b1) begin n_fail++; $display("FAIL areset_flags: flags %b stall %b want 00/1", {ras_overflow, ras_underflow}, fif.stall); end
        #10;
        hazard_stall = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        fif.instruction = 16'h0000;
        fif.NPC         = 16'h0000;
        hazard_stall    = 1'b0;
        rs_equal        = 1'b0;
        rst_n           = 1'b0;
        test_reset();
        test_sequential();
        test_jmp();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
